// File: rtl/fifo_pkg.sv
// Shared helpers for the asynchronous FIFO pointer logic: pointer width
// derivation and Gray/binary conversion usable at any pointer width.
package fifo_pkg;

    // Widest pointer the conversion helpers handle; callers zero-extend into
    // this width and truncate the result back to their own pointer width.
    localparam int PTR_MAX_W = 32;

    // Pointers carry one extra wrap bit beyond the memory address.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above its position;
    // zero-extended upper bits contribute nothing.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
        logic [PTR_MAX_W-1:0] bin;
        bin = gray;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Only one bit changes per pointer step, so a plain flop chain is safe.
module ptr_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // Shift the asynchronous pointer through the chain; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/r_ptr_empty.sv
// Read-side pointer and empty/level logic of the asynchronous FIFO.
// Holds the binary read pointer, exports its Gray form to the write domain,
// and derives empty, almost-empty, occupancy and underflow from the
// synchronized write pointer.
module r_ptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_en,
    input  logic [ADDR_WIDTH:0]   w_gray_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_gray_ptr,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  r_underflow
);

    localparam int PTR_W = ptr_width(ADDR_WIDTH);
    localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] r_bin;
    logic [PTR_W-1:0] r_bin_next;
    logic [PTR_W-1:0] r_gray_next;
    logic [PTR_W-1:0] wq_gray;
    logic [PTR_W-1:0] wq_bin;
    logic [PTR_W-1:0] level_next;
    logic             rd_ok;

    // Write pointer crossing into the read domain.
    ptr_sync #(
        .WIDTH       (PTR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk (r_clk),
        .rst (r_rst),
        .d   (w_gray_ptr),
        .q   (wq_gray)
    );

    // Requests while empty are dropped so the pointer never passes the writer.
    assign rd_ok       = r_en & ~r_empty;
    assign r_bin_next  = r_bin + PTR_W'(rd_ok);
    assign r_gray_next = PTR_W'(bin2gray(PTR_MAX_W'(r_bin_next)));
    assign wq_bin      = PTR_W'(gray2bin(PTR_MAX_W'(wq_gray)));
    // Modular difference is the true occupancy because the wrap bit
    // disambiguates full from empty.
    assign level_next  = wq_bin - r_bin_next;
    assign r_addr      = r_bin[ADDR_WIDTH-1:0];

    // Pointer register: binary for addressing, Gray for the domain crossing.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_bin      <= '0;
            r_gray_ptr <= '0;
        end else begin
            r_bin      <= r_bin_next;
            r_gray_ptr <= r_gray_next;
        end
    end

    // Flags and level, all from the same wq_gray sample so they always agree.
    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_empty        <= (r_gray_next == wq_gray);
            r_almost_empty <= (level_next <= AE_TH);
            r_level        <= level_next;
            r_underflow    <= r_en & r_empty;
        end
    end

endmodule

// File: tb/tb_r_ptr_empty.sv
// Directed bench for r_ptr_empty with ADDR_WIDTH=3, SYNC_STAGES=2, AEMPTY_THRESH=1.
module tb_r_ptr_empty;

    logic       r_clk = 1'b0;
    logic       r_rst;
    logic       r_en;
    logic [3:0] w_gray_ptr;
    logic [2:0] r_addr;
    logic [3:0] r_gray_ptr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [3:0] r_level;
    logic       r_underflow;

    int checks   = 0;
    int failures = 0;

    r_ptr_empty #(
        .ADDR_WIDTH    (3),
        .SYNC_STAGES   (2),
        .AEMPTY_THRESH (1)
    ) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .r_en           (r_en),
        .w_gray_ptr     (w_gray_ptr),
        .r_addr         (r_addr),
        .r_gray_ptr     (r_gray_ptr),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_level        (r_level),
        .r_underflow    (r_underflow)
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] w;
        logic [2:0] addr;
        logic [3:0] gray;
        logic       e;
        logic       ae;
        logic [3:0] lvl;
        logic       uf;
    } vec_t;

    vec_t vq[$];

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int addr, input int gray, input int e,
                           input int ae, input int lvl, input int uf);
        chk({tag, "_addr"},  int'(r_addr),         addr);
        chk({tag, "_gray"},  int'(r_gray_ptr),     gray);
        chk({tag, "_empty"}, int'(r_empty),        e);
        chk({tag, "_aempty"}, int'(r_almost_empty), ae);
        chk({tag, "_level"}, int'(r_level),        lvl);
        chk({tag, "_uflow"}, int'(r_underflow),    uf);
    endtask

    initial begin
        logic [3:0] prev_gray;
        logic [3:0] diff;

        r_rst = 1'b1;
        r_en = 1'b0;
        w_gray_ptr = 4'b0000;

        // rst en w | addr gray e ae lvl uf
        // Reset held two cycles
        vq.push_back('{1, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{1, 0, 4'b0000, 0, 4'b0000, 1, 1, 0, 0});
        // Single entry: write pointer visible after the third edge
        vq.push_back('{0, 0, 4'b0001, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b0001, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b0001, 0, 4'b0000, 0, 1, 1, 0});
        // One read empties it on the same edge
        vq.push_back('{0, 1, 4'b0001, 1, 4'b0001, 1, 1, 0, 0});
        // Underflow: three requests while empty, pointer holds
        vq.push_back('{0, 1, 4'b0001, 1, 4'b0001, 1, 1, 0, 1});
        vq.push_back('{0, 1, 4'b0001, 1, 4'b0001, 1, 1, 0, 1});
        vq.push_back('{0, 1, 4'b0001, 1, 4'b0001, 1, 1, 0, 1});
        vq.push_back('{0, 0, 4'b0001, 1, 4'b0001, 1, 1, 0, 0});
        // Reset, then full drain with write pointer at binary 8
        vq.push_back('{1, 0, 4'b1100, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b1100, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b1100, 0, 4'b0000, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b1100, 0, 4'b0000, 0, 0, 8, 0});
        vq.push_back('{0, 1, 4'b1100, 1, 4'b0001, 0, 0, 7, 0});
        vq.push_back('{0, 1, 4'b1100, 2, 4'b0011, 0, 0, 6, 0});
        vq.push_back('{0, 1, 4'b1100, 3, 4'b0010, 0, 0, 5, 0});
        vq.push_back('{0, 1, 4'b1100, 4, 4'b0110, 0, 0, 4, 0});
        vq.push_back('{0, 1, 4'b1100, 5, 4'b0111, 0, 0, 3, 0});
        vq.push_back('{0, 1, 4'b1100, 6, 4'b0101, 0, 0, 2, 0});
        vq.push_back('{0, 1, 4'b1100, 7, 4'b0100, 0, 1, 1, 0});
        vq.push_back('{0, 1, 4'b1100, 0, 4'b1100, 1, 1, 0, 0});
        vq.push_back('{0, 0, 4'b1100, 0, 4'b1100, 1, 1, 0, 0});

        foreach (vq[i]) begin
            r_rst = vq[i].rst;
            r_en = vq[i].en;
            w_gray_ptr = vq[i].w;
            step();
            chk_all($sformatf("v%0d", i), int'(vq[i].addr), int'(vq[i].gray), int'(vq[i].e),
                    int'(vq[i].ae), int'(vq[i].lvl), int'(vq[i].uf));
        end

        // Wrap: start full, then read and write one entry per cycle for 20 reads
        r_rst = 1'b1; r_en = 1'b0; w_gray_ptr = 4'b0000;
        step();
        r_rst = 1'b0; w_gray_ptr = b2g(4'd8);
        step(); step(); step();
        chk_all("wrap_pre", 0, 0, 0, 0, 8, 0);
        prev_gray = 4'b0000;
        for (int i = 1; i <= 20; i++) begin
            r_en = 1'b1;
            w_gray_ptr = b2g(4'((8 + i) % 16));
            step();
            chk($sformatf("wrap%0d_gray", i), int'(r_gray_ptr), int'(b2g(4'(i % 16))));
            chk($sformatf("wrap%0d_addr", i), int'(r_addr), i % 8);
            chk($sformatf("wrap%0d_level", i), int'(r_level), (i == 1) ? 7 : 6);
            chk($sformatf("wrap%0d_empty", i), int'(r_empty), 0);
            diff = r_gray_ptr ^ prev_gray;
            chk($sformatf("wrap%0d_onebit", i), $countones(diff), 1);
            if (i == 16) begin
                chk("wrap_prev_1000", int'(prev_gray), 8);
                chk("wrap_now_0000", int'(r_gray_ptr), 0);
            end
            prev_gray = r_gray_ptr;
        end
        r_en = 1'b0;

        // Reset mid-operation: level 5 with a read pending, reset wins
        r_rst = 1'b1; w_gray_ptr = 4'b0000;
        step();
        r_rst = 1'b0; w_gray_ptr = b2g(4'd5);
        step(); step(); step();
        chk_all("mid_pre", 0, 0, 0, 0, 5, 0);
        r_rst = 1'b1; r_en = 1'b1;
        step();
        chk_all("mid_rst", 0, 0, 1, 1, 0, 0);
        r_rst = 1'b0; r_en = 1'b0;
        step(); step(); step();
        chk_all("mid_post", 0, 0, 0, 0, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
